// File: rtl/adc_pkg.sv
// Shared ADC/DAC definitions: converter state encoding and default geometry.
package adc_pkg;

  localparam int unsigned ADC_WIDTH  = 10;
  localparam int unsigned ADC_NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } adc_state_e;

  // Channel-index width; a single-channel build still carries one tag bit.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sar_adc_seq_if.sv
// Control and result port bundle of the SAR ADC sequencer.
interface sar_adc_seq_if
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH  = ADC_WIDTH,
  parameter int unsigned NUM_CH = ADC_NUM_CH
) ();

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic            start;
  logic            scan_mode;
  logic [CH_W-1:0] ch_sel;
  logic            busy;
  logic [WIDTH-1:0] dout;
  logic [CH_W-1:0] dout_ch;
  logic            dout_valid;
  logic            dout_ready;

  modport master (
    input  start, scan_mode, ch_sel, dout_ready,
    output busy, dout, dout_ch, dout_valid
  );

  modport slave (
    output start, scan_mode, ch_sel, dout_ready,
    input  busy, dout, dout_ch, dout_valid
  );

endinterface

// File: rtl/sar_core.sv
// Successive-approximation register: holds the sampled value and resolves one
// result bit per step, MSB first.
module sar_core #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_samp,
  input  logic             i_step,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_samp;
  logic [WIDTH-1:0] r_result;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] w_trial;

  assign w_trial  = r_result | (WIDTH'(1) << r_idx);
  assign o_done_c = (r_idx == '0);
  assign o_result = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp   <= '0;
      r_result <= '0;
      r_idx    <= '0;
    end else if (i_load) begin
      r_samp   <= i_samp;
      r_result <= '0;
      r_idx    <= IDX_W'(WIDTH - 1);
    end else if (i_step) begin
      if (r_samp >= w_trial) begin
        r_result <= w_trial;
      end
      if (r_idx != '0) begin
        r_idx <= r_idx - IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/sar_adc_seq.sv
// Multi-channel SAR ADC sequencer: FSM, channel sequencing and the
// valid/ready result register around a single sar_core.
module sar_adc_seq
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH  = ADC_WIDTH,
  parameter int unsigned NUM_CH = ADC_NUM_CH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] i_analog_in,
  sar_adc_seq_if.master           io_bus
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  adc_state_e       r_state;
  adc_state_e       w_next;
  logic [CH_W-1:0]  r_cur_ch;
  logic [WIDTH-1:0] r_dout;
  logic [CH_W-1:0]  r_dout_ch;
  logic             r_dout_valid;
  logic             r_busy;

  logic             w_start_acc;
  logic             w_core_load;
  logic             w_core_step;
  logic             w_core_done;
  logic             w_load_out;
  logic [WIDTH-1:0] w_samp;
  logic [WIDTH-1:0] w_result;
  logic [CH_W-1:0]  w_first_ch;
  logic [CH_W-1:0]  w_next_ch;

  sar_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_core_load),
    .i_samp   (w_samp),
    .i_step   (w_core_step),
    .o_done_c (w_core_done),
    .o_result (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (io_bus.start) w_next = SAMPLE;
      SAMPLE:  w_next = CONVERT;
      CONVERT: if (w_core_done) w_next = DONE;
      DONE:    if (w_load_out) w_next = io_bus.scan_mode ? SAMPLE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_start_acc = 1'b0;
    w_core_load = 1'b0;
    w_core_step = 1'b0;
    w_load_out  = 1'b0;
    case (r_state)
      IDLE:    w_start_acc = io_bus.start;
      SAMPLE:  w_core_load = 1'b1;
      CONVERT: w_core_step = 1'b1;
      DONE:    w_load_out  = !r_dout_valid || io_bus.dout_ready;
      default: ;
    endcase
  end

  // Out-of-range requests fall back to channel 0; scan wraps after the last channel.
  assign w_first_ch = (32'(io_bus.ch_sel) >= NUM_CH) ? '0 : io_bus.ch_sel;
  assign w_next_ch  = (r_cur_ch == CH_W'(NUM_CH - 1)) ? '0 : r_cur_ch + CH_W'(1);

  always_comb begin
    w_samp = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_cur_ch == CH_W'(k)) begin
        w_samp = i_analog_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_ch <= '0;
    end else if (w_start_acc) begin
      r_cur_ch <= w_first_ch;
    end else if (w_load_out && io_bus.scan_mode) begin
      r_cur_ch <= w_next_ch;
    end
  end

  // A load in the same cycle as an accept keeps valid high with fresh data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      if (w_load_out) begin
        r_dout       <= w_result;
        r_dout_ch    <= r_cur_ch;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && io_bus.dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign io_bus.busy       = r_busy;
  assign io_bus.dout       = r_dout;
  assign io_bus.dout_ch    = r_dout_ch;
  assign io_bus.dout_valid = r_dout_valid;

endmodule

// File: tb/tb_sar_adc_seq.sv
// Self-checking bench for sar_adc_seq: vector table plus scoreboarded
// multi-cycle sequences (scan, backpressure, track-and-hold, abort).
module tb_sar_adc_seq;
  import adc_pkg::*;

  localparam int unsigned WIDTH  = 10;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = ch_width(NUM_CH);
  localparam int unsigned LAT    = WIDTH + 2;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_CH*WIDTH-1:0] analog_in;

  sar_adc_seq_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

  sar_adc_seq #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_analog_in (analog_in),
    .io_bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] data;
  } res_t;

  typedef struct {
    logic [CH_W-1:0]  ch_sel;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] exp_dout;
    logic [CH_W-1:0]  exp_ch;
  } vec_t;

  res_t        exp_q[$];
  int unsigned stamp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int          n_rx     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
      n_rx++;
      stamp_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got ch %0d data 0x%0h expected none",
                 bus.dout_ch, bus.dout);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("result_data", 32'(bus.dout), 32'(e.data));
        check("result_ch", 32'(bus.dout_ch), 32'(e.ch));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_channels();
    for (int k = 0; k < NUM_CH; k++) analog_in[k*WIDTH +: WIDTH] = WIDTH'(k * 37 + 5);
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] v);
    analog_in[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic pulse_start(input logic [CH_W-1:0] ch, input logic scan);
    bus.ch_sel    = ch;
    bus.scan_mode = scan;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_rx(input int target, input int max_cyc, input string name);
    int n = 0;
    while (n_rx < target && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 32'(n_rx), 32'(target));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{ch_sel: 2'd2, val: 10'h2A5, exp_dout: 10'h2A5, exp_ch: 2'd2};
    vecs[1] = '{ch_sel: 2'd0, val: 10'h000, exp_dout: 10'h000, exp_ch: 2'd0};
    vecs[2] = '{ch_sel: 2'd0, val: 10'h3FF, exp_dout: 10'h3FF, exp_ch: 2'd0};
    vecs[3] = '{ch_sel: 2'd1, val: 10'h155, exp_dout: 10'h155, exp_ch: 2'd1};
    vecs[4] = '{ch_sel: 2'd3, val: 10'h200, exp_dout: 10'h200, exp_ch: 2'd3};
    vecs[5] = '{ch_sel: 2'd2, val: 10'h001, exp_dout: 10'h001, exp_ch: 2'd2};

    rst            = 1'b1;
    analog_in      = '0;
    bus.start      = 1'b0;
    bus.scan_mode  = 1'b0;
    bus.ch_sel     = '0;
    bus.dout_ready = 1'b0;
    repeat (3) tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_dout", 32'(bus.dout), 32'd0);
    check("reset_dout_ch", 32'(bus.dout_ch), 32'd0);
    check("reset_valid", 32'(bus.dout_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Single-shot vectors: latency, value, tag, and return to idle.
    bus.dout_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      int lat;
      fill_channels();
      set_ch(int'(vecs[v].ch_sel), vecs[v].val);
      exp_q.push_back('{ch: vecs[v].exp_ch, data: vecs[v].exp_dout});
      pulse_start(vecs[v].ch_sel, 1'b0);
      lat = 0;
      while (bus.dout_valid !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      check("single_latency", 32'(lat), 32'(LAT));
      check("single_dout", 32'(bus.dout), 32'(vecs[v].exp_dout));
      check("single_busy_after", 32'(bus.busy), 32'd0);
      tick();
      check("single_valid_clear", 32'(bus.dout_valid), 32'd0);
    end

    // Scan from channel 3 wraps to 0; dropping scan_mode finishes one more conversion.
    set_ch(0, 10'h011);
    set_ch(1, 10'h022);
    set_ch(2, 10'h033);
    set_ch(3, 10'h044);
    stamp_q.delete();
    begin
      int base;
      base = n_rx;
      exp_q.push_back('{ch: 2'd3, data: 10'h044});
      exp_q.push_back('{ch: 2'd0, data: 10'h011});
      exp_q.push_back('{ch: 2'd1, data: 10'h022});
      exp_q.push_back('{ch: 2'd2, data: 10'h033});
      pulse_start(2'd3, 1'b1);
      wait_rx(base + 4, 100, "scan_four_results");
      bus.scan_mode = 1'b0;
      exp_q.push_back('{ch: 2'd3, data: 10'h044});
      wait_rx(base + 5, 30, "scan_drop_finishes");
      wait_idle(30, "scan_idle");
      for (int i = 0; i + 1 < stamp_q.size(); i++)
        check("scan_interval", stamp_q[i+1] - stamp_q[i], 32'(LAT));
    end

    // Backpressure: stall in DONE, then accept and reload on the same edge.
    bus.dout_ready = 1'b0;
    set_ch(0, 10'h101);
    set_ch(1, 10'h102);
    set_ch(2, 10'h103);
    set_ch(3, 10'h104);
    begin
      int base;
      base = n_rx;
      exp_q.push_back('{ch: 2'd0, data: 10'h101});
      exp_q.push_back('{ch: 2'd1, data: 10'h102});
      pulse_start(2'd0, 1'b1);
      repeat (40) tick();
      check("stall_valid", 32'(bus.dout_valid), 32'd1);
      check("stall_dout", 32'(bus.dout), 32'h101);
      check("stall_dout_ch", 32'(bus.dout_ch), 32'd0);
      check("stall_busy", 32'(bus.busy), 32'd1);
      bus.scan_mode  = 1'b0;
      bus.dout_ready = 1'b1;
      tick();
      check("reload_valid", 32'(bus.dout_valid), 32'd1);
      check("reload_dout", 32'(bus.dout), 32'h102);
      check("reload_dout_ch", 32'(bus.dout_ch), 32'd1);
      check("reload_busy", 32'(bus.busy), 32'd0);
      wait_rx(base + 2, 10, "stall_results");
      tick();
      check("stall_valid_clear", 32'(bus.dout_valid), 32'd0);
    end

    // Track-and-hold: input changes after the SAMPLE edge; a start while busy is ignored.
    begin
      int base;
      base = n_rx;
      set_ch(1, 10'h0F0);
      exp_q.push_back('{ch: 2'd1, data: 10'h0F0});
      pulse_start(2'd1, 1'b0);
      tick();
      set_ch(1, 10'h30F);
      tick();
      bus.ch_sel = 2'd3;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      wait_idle(30, "hold_idle");
      repeat (15) tick();
      check("hold_no_extra", 32'(n_rx), 32'(base + 1));
      check("hold_busy", 32'(bus.busy), 32'd0);
    end

    // Abort: reset during the 5th CONVERT cycle discards the conversion.
    set_ch(2, 10'h123);
    pulse_start(2'd2, 1'b0);
    tick();
    repeat (4) tick();
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.dout_valid), 32'd0);
    check("abort_dout", 32'(bus.dout), 32'd0);
    check("abort_dout_ch", 32'(bus.dout_ch), 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("abort_quiet_busy", 32'(bus.busy), 32'd0);
    check("abort_quiet_valid", 32'(bus.dout_valid), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
